// File: rtl/pc_count_sevenseg_if.sv
// ---------------------------------------------------------------------------
// pc_count_sevenseg_if
//
// Groups the data and display signals of the seven-segment display stage that
// sits after the 15:4 parallel counter.
//
//   d_in       [14:0]  vector presented to the counter (switch bank)
//   count_in   [3:0]   counter result, 0..15
//   seg_n      [6:0]   cathodes {g,f,e,d,c,b,a}, active-low
//   dp_n               decimal point, active-low
//   an_n       [7:0]   digit anodes, active-low, bit i = digit i
//   frame_tick         one-cycle pulse marking the snapshot
//
// Modports:
//   master : upstream/board side, drives d_in/count_in and observes the display
//   slave  : the display stage itself
// ---------------------------------------------------------------------------
interface pc_count_sevenseg_if;
    logic [14:0] d_in;
    logic [3:0]  count_in;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic        frame_tick;

    modport master (
        output d_in, count_in,
        input  seg_n, dp_n, an_n, frame_tick
    );

    modport slave (
        input  d_in, count_in,
        output seg_n, dp_n, an_n, frame_tick
    );
endinterface

// File: rtl/pc_count_sevenseg.sv
// ---------------------------------------------------------------------------
// pc_count_sevenseg
//
// Scans an 8-digit common-anode seven-segment display. Once per frame it
// snapshots the counter input vector and population count, then shows:
//   digits 1:0  count in decimal
//   digits 3:2  dark
//   digits 7:4  input vector in hex (digit 4 carries the decimal point as a
//               separator between the hex and decimal fields)
// Each digit slot begins with GUARD_CYC cycles of all anodes off so the
// previous digit's cathode pattern cannot ghost onto the next digit.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   GUARD_CYC    anodes-off cycles at the start of each slot (< REFRESH_DIV)
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    pc_count_sevenseg_if.slave (d_in, count_in in; seg_n, dp_n, an_n,
//          frame_tick out)
//
// Build option:
//   PC_SEG_LZB_EN  when defined, the count tens digit is blanked for counts
//                  below 10; otherwise it always shows "0" or "1".
//
// All outputs are registered: they follow slot_cnt/digit_idx by one cycle.
// ---------------------------------------------------------------------------
module pc_count_sevenseg #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pc_count_sevenseg_if.slave  bus
);

    localparam int                SLOT_W    = $clog2(REFRESH_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);

    // Scan state and frame shadow registers
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]        digit_idx_q, digit_idx_d;
    logic [14:0]       d_q, d_d;
    logic [3:0]        cnt_q, cnt_d;

    // Registered outputs
    logic [6:0]        seg_n_q, seg_n_d;
    logic              dp_n_q, dp_n_d;
    logic [7:0]        an_n_q, an_n_d;
    logic              frame_tick_q, frame_tick_d;

    logic              slot_end;
    logic              snap;
    logic              in_guard;
    logic              cnt_ge10;
    logic [3:0]        cnt_ones;
    logic [3:0]        cnt_tens;
    logic [3:0]        digit_val [8];
    logic [7:0]        digit_blank;
    logic [7:0]        an_sel;
    logic              cur_blank;
    logic              lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Anodes are suppressed for the first GUARD_CYC cycles of every slot.
    // The zero-guard case is split out so no always-false compare is built.
    if (GUARD_CYC == 0) begin : g_no_guard
        assign in_guard = 1'b0;
    end else begin : g_guard
        localparam logic [SLOT_W-1:0] SLOT_GUARD = SLOT_W'(GUARD_CYC);
        assign in_guard = (slot_cnt_q < SLOT_GUARD);
    end

    // One-hot digit select, inverted later into the active-low anode bus
    for (genvar gi = 0; gi < 8; gi++) begin : g_an_sel
        assign an_sel[gi] = (digit_idx_q == 3'(gi));
    end

    // Count is at most 15, so binary-to-BCD is a single compare/subtract.
    always_comb begin
        cnt_ge10 = (cnt_q >= 4'd10);
        cnt_ones = cnt_ge10 ? (cnt_q - 4'd10) : cnt_q;
        cnt_tens = cnt_ge10 ? 4'd1 : 4'd0;
    end

    always_comb begin
        digit_val[0] = cnt_ones;
        digit_val[1] = cnt_tens;
        digit_val[2] = 4'h0;
        digit_val[3] = 4'h0;
        digit_val[4] = d_q[3:0];
        digit_val[5] = d_q[7:4];
        digit_val[6] = d_q[11:8];
        digit_val[7] = {1'b0, d_q[14:12]};

        digit_blank = 8'b0000_1100;
`ifdef PC_SEG_LZB_EN
        digit_blank[1] = ~cnt_ge10;
`endif
    end

    // Scan counters and frame snapshot
    always_comb begin
        slot_end    = (slot_cnt_q == SLOT_LAST);
        snap        = (slot_cnt_q == '0) && (digit_idx_q == 3'd0);
        slot_cnt_d  = slot_end ? '0 : (slot_cnt_q + SLOT_W'(1));
        digit_idx_d = slot_end ? (digit_idx_q + 3'd1) : digit_idx_q;
        // Shadow registers only move at the frame boundary, so a scan never
        // mixes data from two different snapshots.
        d_d         = snap ? bus.d_in     : d_q;
        cnt_d       = snap ? bus.count_in : cnt_q;
    end

    // Next output values, registered below
    always_comb begin
        cur_blank    = digit_blank[digit_idx_q];
        lit          = ~cur_blank & ~in_guard;
        an_n_d       = lit ? ~an_sel : 8'hFF;
        seg_n_d      = cur_blank ? 7'h7F : hex_to_seg(digit_val[digit_idx_q]);
        dp_n_d       = ~(lit & (digit_idx_q == 3'd4));
        frame_tick_d = snap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            digit_idx_q  <= 3'd0;
            d_q          <= 15'd0;
            cnt_q        <= 4'd0;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_n_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_idx_q  <= digit_idx_d;
            d_q          <= d_d;
            cnt_q        <= cnt_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.seg_n      = seg_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
